// File: rtl/lcd_text_frame_driver.sv
// HD44780 character-LCD driver with an on-chip ROWSxCOLS text buffer.
// Runs power-up init, then streams only rows that the host has marked dirty.
module lcd_text_frame_driver #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int ROWS       = 2,
   parameter int COLS       = 16,
   parameter int BUS4       = 0,
   parameter int E_CYC      = 50,
   parameter int T_CMD_US   = 50,
   parameter int T_CLR_US   = 2000,
   parameter int T_PWRUP_MS = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [1:0] wr_row,
   input  logic [4:0] wr_col,
   input  logic [7:0] wr_char,
   input  logic       refresh_req,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam int TICK     = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
   localparam int PWRUP_US = T_PWRUP_MS * 1000;
   localparam int WAIT_A   = (PWRUP_US > T_CLR_US) ? PWRUP_US : T_CLR_US;
   localparam int WAIT_MAX = (WAIT_A > T_CMD_US) ? WAIT_A : T_CMD_US;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int PRE_W    = $clog2(TICK + 1);
   localparam int CYC_W    = $clog2(E_CYC + 1);
   localparam int CELLS    = ROWS * COLS;

   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK - 1);
   localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(E_CYC - 1);
   localparam logic [2:0]       ROWS_L   = 3'(ROWS);
   localparam logic [4:0]       COLS_L   = 5'(COLS);

   localparam logic [2:0] ST_PWRUP   = 3'd0;
   localparam logic [2:0] ST_INIT    = 3'd1;
   localparam logic [2:0] ST_IDLE    = 3'd2;
   localparam logic [2:0] ST_ROWADDR = 3'd3;
   localparam logic [2:0] ST_ROWDATA = 3'd4;

   localparam logic [2:0] PH_OFF   = 3'd0;
   localparam logic [2:0] PH_SETUP = 3'd1;
   localparam logic [2:0] PH_EHIGH = 3'd2;
   localparam logic [2:0] PH_HOLD  = 3'd3;
   localparam logic [2:0] PH_WAIT  = 3'd4;

   if (!(ROWS == 1 || ROWS == 2 || ROWS == 4)) begin : g_bad_rows
      $error("lcd_text_frame_driver: ROWS must be 1, 2 or 4");
   end
   if (COLS < 1 || COLS > 20) begin : g_bad_cols
      $error("lcd_text_frame_driver: COLS must be in 1..20");
   end

   logic [2:0]        state_reg, state_next;
   logic [2:0]        phase_reg;
   logic [2:0]        step_reg, step_next;
   logic [4:0]        col_reg, col_next;
   logic [1:0]        row_reg, row_next;
   logic [ROWS-1:0]   dirty_reg, dirty_next;
   logic [CYC_W-1:0]  cyc_reg;
   logic [PRE_W-1:0]  pre_reg;
   logic [WAIT_W-1:0] wait_reg;
   logic [7:0]        tx_reg;
   logic              hi_nib_reg, single_reg, long_reg;

   logic              launch, l_rs, l_long, l_single, pick, set_all;
   logic [7:0]        l_byte, rd_char;
   logic [1:0]        low_row;
   logic              wr_ok;
   logic [6:0]        wr_idx, rd_idx;
   logic [7:0]        char_mem [CELLS];

   function automatic logic [7:0] row_addr(input logic [1:0] r);
      case (r)
         2'd0:    return 8'h80;
         2'd1:    return 8'hC0;
         2'd2:    return 8'h94;
         default: return 8'hD4;
      endcase
   endfunction

   function automatic logic [7:0] init_cmd(input logic [2:0] s);
      case (s)
         3'd0:    return (BUS4 != 0) ? 8'h28 : 8'h38;
         3'd1:    return 8'h08;
         3'd2:    return 8'h01;
         3'd3:    return 8'h06;
         default: return 8'h0C;
      endcase
   endfunction

   assign wr_ok  = wr_en && ({1'b0, wr_row} < ROWS_L) && (wr_col < COLS_L);
   assign wr_idx = 7'(wr_row) * 7'(COLS) + 7'(wr_col);
   assign rd_idx = 7'(row_reg) * 7'(COLS) + 7'(col_reg);
   assign busy   = !(state_reg == ST_IDLE && dirty_reg == '0);
   assign lcd_rw = 1'b0;

   // Buffer cells reset to ASCII space so a fresh display shows blanks.
   for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      logic [7:0] cell_reg;
      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            cell_reg <= 8'h20;
         else if (wr_ok && wr_idx == 7'(gi))
            cell_reg <= wr_char;
      end
      assign char_mem[gi] = cell_reg;
   end

   always_comb begin
      rd_char = 8'h20;
      for (int i = 0; i < CELLS; i++)
         if (rd_idx == 7'(i)) rd_char = char_mem[i];
   end

   always_comb begin
      low_row = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--)
         if (dirty_reg[i]) low_row = 2'(i);
   end

   // Sequencer: decides the next bus transfer whenever the byte engine is free.
   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      launch     = 1'b0;
      l_byte     = 8'h00;
      l_rs       = 1'b0;
      l_long     = 1'b0;
      l_single   = 1'b0;
      pick       = 1'b0;
      set_all    = 1'b0;
      if (phase_reg == PH_OFF) begin
         case (state_reg)
            ST_PWRUP: begin
               if (BUS4 != 0 && step_reg < 3'd4) begin
                  launch    = 1'b1;
                  l_single  = 1'b1;
                  l_long    = 1'b1;
                  l_byte    = (step_reg == 3'd3) ? 8'h20 : 8'h30;
                  step_next = step_reg + 1'b1;
               end else begin
                  state_next = ST_INIT;
                  step_next  = 3'd0;
               end
            end
            ST_INIT: begin
               if (step_reg < 3'd5) begin
                  launch    = 1'b1;
                  l_byte    = init_cmd(step_reg);
                  l_long    = (step_reg == 3'd2);
                  step_next = step_reg + 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  set_all    = 1'b1;
               end
            end
            ST_IDLE: begin
               if (dirty_reg != '0) begin
                  pick       = 1'b1;
                  row_next   = low_row;
                  launch     = 1'b1;
                  l_byte     = row_addr(low_row);
                  state_next = ST_ROWADDR;
               end
            end
            ST_ROWADDR: begin
               state_next = ST_ROWDATA;
               col_next   = 5'd0;
            end
            ST_ROWDATA: begin
               if (col_reg < COLS_L) begin
                  launch   = 1'b1;
                  l_rs     = 1'b1;
                  l_byte   = rd_char;
                  col_next = col_reg + 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_PWRUP;
         endcase
      end
   end

   // Clear-on-pick comes first so a same-cycle host write re-dirties the row.
   always_comb begin
      dirty_next = dirty_reg;
      for (int i = 0; i < ROWS; i++) begin
         if (pick && low_row == 2'(i)) dirty_next[i] = 1'b0;
         if (set_all || refresh_req) dirty_next[i] = 1'b1;
         if (wr_ok && wr_row == 2'(i)) dirty_next[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_PWRUP;
         phase_reg  <= PH_WAIT;
         wait_reg   <= WAIT_W'(PWRUP_US);
         pre_reg    <= PRE_LOAD;
         cyc_reg    <= '0;
         step_reg   <= 3'd0;
         col_reg    <= 5'd0;
         row_reg    <= 2'd0;
         dirty_reg  <= '0;
         tx_reg     <= 8'h00;
         hi_nib_reg <= 1'b0;
         single_reg <= 1'b0;
         long_reg   <= 1'b0;
         lcd_e      <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
         dirty_reg <= dirty_next;
         case (phase_reg)
            PH_OFF: begin
               if (launch) begin
                  phase_reg  <= PH_SETUP;
                  cyc_reg    <= CYC_LOAD;
                  tx_reg     <= l_byte;
                  lcd_rs     <= l_rs;
                  lcd_data   <= (BUS4 != 0) ? {l_byte[7:4], 4'h0} : l_byte;
                  hi_nib_reg <= 1'b1;
                  single_reg <= l_single;
                  long_reg   <= l_long;
               end
            end
            PH_SETUP: begin
               if (cyc_reg == '0) begin
                  phase_reg <= PH_EHIGH;
                  lcd_e     <= 1'b1;
                  cyc_reg   <= CYC_LOAD;
               end else begin
                  cyc_reg <= cyc_reg - 1'b1;
               end
            end
            PH_EHIGH: begin
               if (cyc_reg == '0) begin
                  phase_reg <= PH_HOLD;
                  lcd_e     <= 1'b0;
                  cyc_reg   <= CYC_LOAD;
               end else begin
                  cyc_reg <= cyc_reg - 1'b1;
               end
            end
            PH_HOLD: begin
               if (cyc_reg != '0) begin
                  cyc_reg <= cyc_reg - 1'b1;
               end else if (BUS4 != 0 && hi_nib_reg && !single_reg) begin
                  phase_reg  <= PH_SETUP;
                  lcd_data   <= {tx_reg[3:0], 4'h0};
                  hi_nib_reg <= 1'b0;
                  cyc_reg    <= CYC_LOAD;
               end else begin
                  phase_reg <= PH_WAIT;
                  wait_reg  <= long_reg ? WAIT_W'(T_CLR_US) : WAIT_W'(T_CMD_US);
                  pre_reg   <= PRE_LOAD;
               end
            end
            PH_WAIT: begin
               if (pre_reg == '0) begin
                  pre_reg <= PRE_LOAD;
                  if (wait_reg <= WAIT_W'(1))
                     phase_reg <= PH_OFF;
                  else
                     wait_reg <= wait_reg - 1'b1;
               end else begin
                  pre_reg <= pre_reg - 1'b1;
               end
            end
            default: phase_reg <= PH_OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_frame_driver.sv
// Directed bench: three driver instances (8-bit 2x16, 4-bit 2x16, 8-bit 4x20),
// bus bytes decoded on the falling edge of lcd_e and compared to hand-built frames.
module tb_lcd_text_frame_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset0, reset12;
   logic       wr_en, refresh_req;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_char;

   logic       busy0, e0, rs0, rw0;
   logic       busy1, e1, rs1, rw1;
   logic       busy2, e2, rs2, rw2;
   logic [7:0] d0, d1, d2;
   logic [2:0] busy_v;
   assign busy_v = {busy2, busy1, busy0};

   lcd_text_frame_driver #(.CLK_HZ(1_000_000), .ROWS(2), .COLS(16), .BUS4(0),
                           .E_CYC(2), .T_PWRUP_MS(1)) u0 (
      .clk(clk), .reset(reset0), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_char(wr_char), .refresh_req(refresh_req), .busy(busy0), .lcd_e(e0),
      .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(d0));

   lcd_text_frame_driver #(.CLK_HZ(1_000_000), .ROWS(2), .COLS(16), .BUS4(1),
                           .E_CYC(2), .T_PWRUP_MS(1)) u1 (
      .clk(clk), .reset(reset12), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_char(wr_char), .refresh_req(refresh_req), .busy(busy1), .lcd_e(e1),
      .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(d1));

   lcd_text_frame_driver #(.CLK_HZ(1_000_000), .ROWS(4), .COLS(20), .BUS4(0),
                           .E_CYC(2), .T_PWRUP_MS(1)) u2 (
      .clk(clk), .reset(reset12), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_char(wr_char), .refresh_req(refresh_req), .busy(busy2), .lcd_e(e2),
      .lcd_rs(rs2), .lcd_rw(rw2), .lcd_data(d2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [8:0] log0[$], log1[$], log2[$];
   int         tm0[$], tm1[$];
   logic [8:0] snap0, snap1;

   always @(posedge e0) snap0 = {rs0, d0};
   always @(posedge e1) snap1 = {rs1, d1};

   always @(negedge e0) if (!reset0) begin
      check("stable0", 32'({rs0, d0}), 32'(snap0));
      log0.push_back({rs0, d0});
      tm0.push_back(cyc);
   end
   always @(negedge e1) if (!reset12) begin
      check("stable1", 32'({rs1, d1}), 32'(snap1));
      log1.push_back({rs1, d1});
      tm1.push_back(cyc);
   end
   always @(negedge e2) if (!reset12) log2.push_back({rs2, d2});

   // Expected 2x16 power-on stream: 5 init commands, then both rows of blanks.
   function automatic logic [8:0] init_frame(input int k, input logic bus4);
      case (k)
         0:       return bus4 ? 9'h028 : 9'h038;
         1:       return 9'h008;
         2:       return 9'h001;
         3:       return 9'h006;
         4:       return 9'h00C;
         5:       return 9'h080;
         22:      return 9'h0C0;
         default: return 9'h120;
      endcase
   endfunction

   function automatic logic [8:0] nib_byte(input int k);
      logic [8:0] hi, lo;
      hi = log1[k];
      lo = log1[k + 1];
      return {hi[8], hi[7:4], lo[7:4]};
   endfunction

   task automatic do_write(input logic we, input logic [1:0] r, input logic [4:0] c,
                           input logic [7:0] ch, input logic refr);
      @(posedge clk); #1;
      wr_en = we; wr_row = r; wr_col = c; wr_char = ch; refresh_req = refr;
      @(posedge clk); #1;
      wr_en = 1'b0; refresh_req = 1'b0;
   endtask

   task automatic wait_idle(input int idx, input int budget, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy_v[idx]) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic clear_logs();
      log0.delete(); log1.delete(); log2.delete();
      tm0.delete(); tm1.delete();
   endtask

   initial begin
      #700000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       found, lo_or;
      logic [8:0] v;

      reset0 = 1'b1; reset12 = 1'b1;
      wr_en = 1'b0; refresh_req = 1'b0; wr_row = 2'd0; wr_col = 5'd0; wr_char = 8'h00;
      repeat (3) @(posedge clk); #1;
      check("rst_busy", 32'(busy0), 32'd1);
      check("rst_e", 32'(e0), 32'd0);
      check("rst_rs", 32'(rs0), 32'd0);
      check("rst_data", 32'(d0), 32'd0);
      check("rst_rw", 32'(rw0), 32'd0);
      reset0 = 1'b0; reset12 = 1'b0;

      // 1. 8-bit power-up and initial frame
      repeat (990) @(posedge clk); #1;
      check("pwrup_quiet0", 32'(log0.size()), 32'd0);
      check("pwrup_quiet1", 32'(log1.size()), 32'd0);
      wait_idle(0, 20000, "idle0_init");
      wait_idle(1, 20000, "idle1_init");
      wait_idle(2, 20000, "idle2_init");
      check("init0_count", 32'(log0.size()), 32'd39);
      if (log0.size() == 39) begin
         for (int k = 0; k < 39; k++) check($sformatf("init0_b%0d", k), 32'(log0[k]), 32'(init_frame(k, 1'b0)));
         check("clr_gap0", 32'((tm0[3] - tm0[2]) >= 2000), 32'd1);
         check("cmd_gap0", 32'((tm0[1] - tm0[0]) inside {[50:200]}), 32'd1);
      end
      check("busy0_idle", 32'(busy0), 32'd0);

      // 3. 4-bit bus: four single nibbles, then byte pairs
      check("init1_count", 32'(log1.size()), 32'd82);
      if (log1.size() == 82) begin
         check("nib0", 32'(log1[0]), 32'h030);
         check("nib1", 32'(log1[1]), 32'h030);
         check("nib2", 32'(log1[2]), 32'h030);
         check("nib3", 32'(log1[3]), 32'h020);
         check("fs_hi", 32'(log1[4]), 32'h020);
         check("fs_lo", 32'(log1[5]), 32'h080);
         for (int k = 0; k < 39; k++) check($sformatf("init1_b%0d", k), 32'(nib_byte(4 + 2 * k)), 32'(init_frame(k, 1'b1)));
         lo_or = 1'b0;
         for (int k = 0; k < 82; k++) begin
            v = log1[k];
            lo_or = lo_or | (|v[3:0]);
         end
         check("low_nib_zero", 32'(lo_or), 32'd0);
         check("pwrup_nib_gap", 32'((tm1[1] - tm1[0]) >= 2000), 32'd1);
         check("nib_pair_gap", 32'((tm1[5] - tm1[4]) <= 10), 32'd1);
      end

      // 6a. 4x20 row addresses
      check("init2_count", 32'(log2.size()), 32'd89);
      if (log2.size() == 89) begin
         check("addr_r0", 32'(log2[5]), 32'h080);
         check("addr_r1", 32'(log2[26]), 32'h0C0);
         check("addr_r2", 32'(log2[47]), 32'h094);
         check("addr_r3", 32'(log2[68]), 32'h0D4);
      end

      // 2. single write re-sends only that row
      clear_logs();
      do_write(1'b1, 2'd1, 5'd3, 8'h41, 1'b0);
      wait_idle(0, 5000, "idle0_wr");
      wait_idle(1, 5000, "idle1_wr");
      wait_idle(2, 5000, "idle2_wr");
      check("wr0_count", 32'(log0.size()), 32'd17);
      if (log0.size() == 17) begin
         check("wr0_addr", 32'(log0[0]), 32'h0C0);
         check("wr0_col0", 32'(log0[1]), 32'h120);
         check("wr0_col3", 32'(log0[4]), 32'h141);
         check("wr0_col15", 32'(log0[16]), 32'h120);
      end
      check("wr1_count", 32'(log1.size()), 32'd34);
      if (log1.size() == 34) begin
         check("wr1_addr", 32'(nib_byte(0)), 32'h0C0);
         check("wr1_col3", 32'(nib_byte(8)), 32'h141);
      end
      check("wr2_count", 32'(log2.size()), 32'd21);
      if (log2.size() == 21) check("wr2_col3", 32'(log2[4]), 32'h141);

      // refresh and write in the same cycle
      clear_logs();
      do_write(1'b1, 2'd1, 5'd0, 8'h42, 1'b1);
      wait_idle(0, 5000, "idle0_rf");
      wait_idle(1, 8000, "idle1_rf");
      wait_idle(2, 8000, "idle2_rf");
      check("rf0_count", 32'(log0.size()), 32'd34);
      if (log0.size() == 34) begin
         check("rf0_a0", 32'(log0[0]), 32'h080);
         check("rf0_a1", 32'(log0[17]), 32'h0C0);
         check("rf0_c0", 32'(log0[18]), 32'h142);
         check("rf0_c3", 32'(log0[21]), 32'h141);
      end
      check("rf2_count", 32'(log2.size()), 32'd84);
      if (log2.size() == 84) check("rf2_a3", 32'(log2[63]), 32'h0D4);

      // 4. write to the row currently on the bus
      clear_logs();
      do_write(1'b1, 2'd0, 5'd0, 8'h31, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (log0.size() == 3 && e0) begin found = 1'b1; break; end
      end
      check("col2_on_bus", 32'(found), 32'd1);
      do_write(1'b1, 2'd0, 5'd15, 8'h5A, 1'b0);
      wait_idle(0, 5000, "idle0_race");
      check("race_count", 32'(log0.size()), 32'd34);
      if (log0.size() == 34) begin
         check("race_a0", 32'(log0[0]), 32'h080);
         check("race_a1", 32'(log0[17]), 32'h080);
         check("race_c0", 32'(log0[18]), 32'h131);
         check("race_c15", 32'(log0[33]), 32'h15A);
      end
      wait_idle(1, 8000, "idle1_race");
      wait_idle(2, 8000, "idle2_race");

      // 5. reset during E-high of a data byte
      clear_logs();
      do_write(1'b0, 2'd0, 5'd0, 8'h00, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (log0.size() >= 2 && e0 && rs0) begin found = 1'b1; break; end
      end
      check("data_ehigh", 32'(found), 32'd1);
      reset0 = 1'b1;
      #1;
      check("rst_e_drop", 32'(e0), 32'd0);
      check("rst_busy2", 32'(busy0), 32'd1);
      check("rst_data2", 32'(d0), 32'd0);
      repeat (3) @(posedge clk); #1;
      reset0 = 1'b0;
      log0.delete(); tm0.delete();
      repeat (990) @(posedge clk); #1;
      check("pwrup_quiet0b", 32'(log0.size()), 32'd0);
      wait_idle(0, 20000, "idle0_reinit");
      check("reinit_count", 32'(log0.size()), 32'd39);
      if (log0.size() == 39) begin
         check("reinit_b0", 32'(log0[0]), 32'h038);
         check("reinit_b2", 32'(log0[2]), 32'h001);
         check("reinit_addr", 32'(log0[5]), 32'h080);
         check("reinit_blank", 32'(log0[6]), 32'h120);
      end

      // 6b. out-of-range write is ignored
      wait_idle(1, 8000, "idle1_end");
      wait_idle(2, 8000, "idle2_end");
      clear_logs();
      do_write(1'b1, 2'd2, 5'd20, 8'h55, 1'b0);
      check("oor_busy2", 32'(busy2), 32'd0);
      check("oor_busy0", 32'(busy0), 32'd0);
      repeat (200) @(posedge clk); #1;
      check("oor_quiet2", 32'(log2.size()), 32'd0);
      check("oor_quiet0", 32'(log0.size()), 32'd0);
      check("oor_busy2b", 32'(busy2), 32'd0);
      check("rw_low", 32'({rw0, rw1, rw2}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
